// File: rtl/csr_pkg.sv
// Shared CSR definitions: AXI response codes, channel FSM states and register
// map bases used by the CSR slave and software-facing blocks.
package csr_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Default register map: control block first, status block right after it.
  localparam int unsigned CSR_N_CTRL    = 8;
  localparam int unsigned CSR_N_STAT    = 8;
  localparam int unsigned CSR_CTRL_BASE = 0;
  localparam int unsigned CSR_STAT_BASE = CSR_CTRL_BASE + CSR_N_CTRL;

endpackage

// File: rtl/axi_lite_csr_slave.sv
// AXI4-Lite slave exposing N_CTRL RW control words and N_STAT RO status words.
// Write and read channels are independent, one outstanding transaction each.
module axi_lite_csr_slave
  import csr_pkg::*;
#(
  parameter int                    N_CTRL   = 8,
  parameter int                    N_STAT   = 8,
  parameter int                    ADDR_W   = 8,
  parameter logic [N_CTRL*32-1:0]  CTRL_RST = '0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [31:0]              awaddr,
  input  logic [2:0]               awprot,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [N_CTRL*32-1:0]     ctrl_o,
  output logic [N_CTRL-1:0]        ctrl_wr_o,
  input  logic [N_STAT*32-1:0]     stat_i
);

  localparam int IDX_W = ADDR_W - 2;

  wr_state_t                  wr_state, wr_next;
  rd_state_t                  rd_state, rd_next;
  logic                       aw_lat, w_lat;
  logic [IDX_W-1:0]           aw_idx_q;
  logic [31:0]                wdata_q;
  logic [3:0]                 wstrb_q;
  axi_resp_t                  bresp_q, rresp_q, rd_resp_n;
  logic [31:0]                rdata_q, rd_data_n;
  logic [N_CTRL-1:0][31:0]    ctrl_q;
  logic [N_CTRL-1:0]          ctrl_wr_q;

  logic                       aw_hs, w_hs, ar_hs, commit, wr_ctrl_hit;
  logic [IDX_W-1:0]           wr_idx, rd_idx;
  logic [31:0]                wr_data;
  logic [3:0]                 wr_strb;

  logic unused;
  assign unused = ^{awprot, arprot, awaddr[31:ADDR_W], awaddr[1:0],
                    araddr[31:ADDR_W], araddr[1:0]};

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;

  // A channel that handshakes this cycle is forwarded straight into the commit,
  // so the write lands on the edge that completes the later of AW and W.
  assign wr_idx  = aw_lat ? aw_idx_q : awaddr[ADDR_W-1:2];
  assign wr_data = w_lat  ? wdata_q  : wdata;
  assign wr_strb = w_lat  ? wstrb_q  : wstrb;
  assign commit  = (wr_state == W_IDLE) && (aw_lat || aw_hs) && (w_lat || w_hs);
  assign wr_ctrl_hit = int'(wr_idx) < N_CTRL;
  assign rd_idx  = araddr[ADDR_W-1:2];

  always_comb begin
    wr_next = wr_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        awready = !aw_lat;
        wready  = !w_lat;
        if (commit) wr_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state  <= W_IDLE;
      aw_lat    <= 1'b0;
      w_lat     <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
      ctrl_q    <= CTRL_RST;
      ctrl_wr_q <= '0;
    end else begin
      wr_state  <= wr_next;
      ctrl_wr_q <= '0;
      if (aw_hs) begin
        aw_lat   <= 1'b1;
        aw_idx_q <= awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_lat   <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) begin
        aw_lat  <= 1'b0;
        w_lat   <= 1'b0;
        bresp_q <= wr_ctrl_hit ? OKAY : SLVERR;
        for (int k = 0; k < N_CTRL; k++) begin
          if (int'(wr_idx) == k) begin
            ctrl_wr_q[k] <= |wr_strb;
            for (int b = 0; b < 4; b++)
              if (wr_strb[b]) ctrl_q[k][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read mux sees ctrl_q before any same-edge write, giving pre-write data.
  always_comb begin
    rd_data_n = '0;
    rd_resp_n = SLVERR;
    for (int k = 0; k < N_CTRL; k++)
      if (int'(rd_idx) == k) begin
        rd_data_n = ctrl_q[k];
        rd_resp_n = OKAY;
      end
    for (int s = 0; s < N_STAT; s++)
      if (int'(rd_idx) == N_CTRL + s) begin
        rd_data_n = stat_i[32*s +: 32];
        rd_resp_n = OKAY;
      end
  end

  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) rd_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rdata_q <= rd_data_n;
        rresp_q <= rd_resp_n;
      end
    end
  end

  assign bresp     = bresp_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign ctrl_o    = ctrl_q;
  assign ctrl_wr_o = ctrl_wr_q;

endmodule

// File: tb/tb_axi_lite_csr_slave.sv
// Directed bench for axi_lite_csr_slave: vector table of single transactions
// plus hand-written sequences for split AW/W, backpressure and mid-read reset.
module tb_axi_lite_csr_slave;

  localparam int N_CTRL = 8;
  localparam int N_STAT = 8;
  localparam logic [N_CTRL*32-1:0] RST_VAL = {192'h0, 32'h1111_2222, 32'hA5A5_0001};

  logic aclk, aresetn;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [N_CTRL*32-1:0] ctrl_o;
  logic [N_CTRL-1:0]    ctrl_wr_o;
  logic [N_STAT*32-1:0] stat_i;

  axi_lite_csr_slave #(.N_CTRL(N_CTRL), .N_STAT(N_STAT), .ADDR_W(8), .CTRL_RST(RST_VAL)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr_o), .stat_i(stat_i)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  always @(negedge aclk) if (|ctrl_wr_o) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    logic aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 20 && (awvalid || wvalid); c++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge aclk); #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    if (awvalid || wvalid) begin
      check("wr_handshake_timeout", 1, 0);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    for (int c = 0; c < 20 && !bvalid; c++) begin @(posedge aclk); #1; end
    resp = bvalid ? bresp : 2'bxx;
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic hs;
    araddr = a; arvalid = 1'b1;
    for (int c = 0; c < 20 && arvalid; c++) begin
      hs = arready;
      @(posedge aclk); #1;
      if (hs) arvalid = 1'b0;
    end
    if (arvalid) begin
      check("rd_handshake_timeout", 1, 0);
      arvalid = 1'b0;
    end
    for (int c = 0; c < 20 && !rvalid; c++) begin @(posedge aclk); #1; end
    d = rvalid ? rdata : 32'hxxxx_xxxx;
    resp = rvalid ? rresp : 2'bxx;
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdat;
  } vec_t;

  vec_t vt[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [255:0] snap;
    int p0;

    // wr, addr, data, strb, resp, expected read data
    vt[0]  = '{0, 32'h0000_0000, 32'h0, 4'h0, 2'b00, 32'hA5A5_0001};
    vt[1]  = '{0, 32'h0000_0004, 32'h0, 4'h0, 2'b00, 32'h1111_2222};
    vt[2]  = '{1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    vt[3]  = '{0, 32'h0000_0008, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF};
    vt[4]  = '{1, 32'h0000_0008, 32'h0, 4'h0, 2'b00, 32'h0};
    vt[5]  = '{0, 32'h0000_0008, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF};
    vt[6]  = '{1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
    vt[7]  = '{0, 32'h0000_00FC, 32'h0, 4'h0, 2'b10, 32'h0};
    vt[8]  = '{0, 32'h0000_0024, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF};
    vt[9]  = '{0, 32'h0000_0020, 32'h0, 4'h0, 2'b00, 32'h5A00_0000};
    vt[10] = '{1, 32'h0000_001C, 32'hAB00_00FF, 4'h8, 2'b00, 32'h0};
    vt[11] = '{0, 32'h0000_001C, 32'h0, 4'h0, 2'b00, 32'hAB00_0000};
    vt[12] = '{1, 32'h1230_000F, 32'h0000_00CC, 4'h1, 2'b00, 32'h0};
    vt[13] = '{1, 32'h0000_0040, 32'h1234_5678, 4'hF, 2'b10, 32'h0};

    for (int k = 0; k < N_STAT; k++) stat_i[32*k +: 32] = 32'h5A00_0000 | k;
    stat_i[63:32] = 32'hDEAD_BEEF;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    aresetn = 1'b0;
    #12;
    check("rst_ready", {awready, wready, arready}, 3'b111);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_resp", {bresp, rresp}, 4'b0000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ctrl", ctrl_o, RST_VAL);
    check("rst_wr_pulse", ctrl_wr_o, 8'h0);
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;

    // Read latency: rvalid one cycle after the AR handshake
    araddr = 32'h0; arvalid = 1'b1;
    check("lat_arready", arready, 1'b1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("lat_rvalid", rvalid, 1'b1);
    check("lat_rdata", {rresp, rdata}, {2'b00, 32'hA5A5_0001});
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    check("lat_rvalid_drop", rvalid, 1'b0);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) begin
        snap = ctrl_o;
        p0 = pulse_cnt;
        do_write(vt[i].addr, vt[i].data, vt[i].strb, r);
        check($sformatf("vec%0d_bresp", i), r, vt[i].resp);
        check($sformatf("vec%0d_pulses", i), pulse_cnt - p0,
              (vt[i].resp == 2'b00 && vt[i].strb != 0) ? 1 : 0);
        if (vt[i].resp != 2'b00 || vt[i].strb == 0)
          check($sformatf("vec%0d_ctrl_kept", i), ctrl_o, snap);
      end else begin
        do_read(vt[i].addr, d, r);
        check($sformatf("vec%0d_rresp", i), r, vt[i].resp);
        check($sformatf("vec%0d_rdata", i), d, vt[i].rdat);
      end
    end
    check("unaligned_wr_ctrl3", ctrl_o[127:96], 32'h0000_00CC);

    // AW first, W three cycles later, partial strobes on register 1
    awaddr = 32'h4; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    check("split_awready_low", {awready, wready}, 2'b01);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    check("split_no_bvalid", bvalid, 1'b0);
    wdata = 32'h1234_5678; wstrb = 4'b0101; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    check("split_ctrl1", ctrl_o[63:32], 32'h1134_2278);
    check("split_pulse", ctrl_wr_o, 8'h02);
    check("split_bresp", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("split_done", {bvalid, ctrl_wr_o, awready, wready}, {1'b0, 8'h00, 2'b11});

    // bready held low: response stalls, concurrent read unaffected
    awaddr = 32'h10; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_hold0", {bvalid, awready, wready}, 3'b100);
    do_read(32'h10, d, r);
    check("bp_read", {r, d}, {2'b00, 32'h0F0F_0F0F});
    check("bp_hold2", {bvalid, awready, wready}, 3'b100);
    for (int c = 0; c < 3; c++) begin
      @(posedge aclk); #1;
      check($sformatf("bp_hold%0d", c + 3), {bvalid, awready, wready}, 3'b100);
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("bp_release", {bvalid, awready, wready}, 3'b011);

    // Reset while rvalid is pending
    araddr = 32'h8; arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("rstmid_rvalid", rvalid, 1'b1);
    #3 aresetn = 1'b0;
    #1;
    check("rstmid_rvalid_clr", rvalid, 1'b0);
    check("rstmid_ctrl", ctrl_o, RST_VAL);
    check("rstmid_rdata", rdata, 32'h0);
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    do_read(32'h4, d, r);
    check("rstmid_read", {r, d}, {2'b00, 32'h1111_2222});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
